seq_alu: RTL
============

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand and result width in bits (legal: 8, 16, 32, 64).
REQ-002 The block SHALL have parameter CHUNK, default 8, operand bits compared per cycle by the Hamming engine (WIDTH % CHUNK == 0).
REQ-003 The block SHALL have port clock, input, 1 bit, the single clock, with all state on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit, request present.
REQ-006 The block SHALL have port in_ready, output, 1 bit, block can accept a request this cycle.
REQ-007 The block SHALL have port a, input, WIDTH bits, operand A (shift amount for shift ops).
REQ-008 The block SHALL have port b, input, WIDTH bits, operand B.
REQ-009 The block SHALL have port aluc, input, 4 bits, operation select.
REQ-010 The block SHALL have port out_valid, output, 1 bit, result held on s/z.
REQ-011 The block SHALL have port out_ready, input, 1 bit, consumer takes result.
REQ-012 The block SHALL have port s, output, WIDTH bits, registered result.
REQ-013 The block SHALL have port z, output, 1 bit, registered zero flag, 1 when s == 0.

Function
REQ-014 A request SHALL be accepted on a rising edge where in_valid && in_ready; a, b and aluc are captured on that edge, and later changes on a, b and aluc have no effect.
REQ-015 The aluc encoding SHALL be:
- 0000 ADD a+b
- 0100 SUB a-b
- 0001 AND
- 0101 OR
- 0010 XOR
- 0110 LUI b<<(WIDTH/2)
- 0011 SLL b<<a
- 0111 SRL b>>a (logical)
- 1111 SRA b>>>a (arithmetic)
- 1000 HAMD, count of differing bit positions of a and b
- any other code: s=0
REQ-016 ADD and SUB SHALL wrap modulo 2^WIDTH; no carry or overflow output.
REQ-017 Shifts SHALL use the full value of a: if a >= WIDTH then SLL and SRL give 0, and SRA gives all bits equal to b[WIDTH-1].
REQ-018 The HAMD result SHALL be zero-extended to WIDTH; its maximum value is WIDTH.
REQ-019 The state machine SHALL have states IDLE, CALC and DONE.
- IDLE: in_ready=1, out_valid=0. On accept of a non-HAMD op, the result is computed and registered on the same edge, next state DONE. On accept of HAMD, the accumulator clears and the chunk index is set to 0, next state CALC.
- CALC: in_ready=0, out_valid=0. Each cycle, the differing-bit count of chunk index i (bits i*CHUNK .. i*CHUNK+CHUNK-1) is added to the accumulator. After chunk WIDTH/CHUNK-1, s and z are loaded, next state DONE.
- DONE: out_valid=1, s and z stable. If out_ready=0, stay in DONE. If out_ready=1 and in_valid=1, accept the new request (in_ready=1 in DONE only while out_ready=1) and branch as from IDLE. If out_ready=1 and in_valid=0, go to IDLE.
REQ-020 Latency from the accept edge to out_valid high SHALL be:
- non-HAMD ops: 1 cycle
- HAMD: WIDTH/CHUNK + 1 cycles
REQ-021 Back-to-back non-HAMD requests with out_ready held at 1 SHALL sustain one result per cycle.
REQ-022 The z output SHALL be updated only when s is loaded and always equal (s == 0).
REQ-023 An undefined aluc SHALL give s=0 and z=1 with non-HAMD latency.
REQ-024 Input changes during CALC or DONE SHALL NOT corrupt the captured operands or the held result.

Reset
REQ-025 When resetn=0, the block SHALL immediately, without waiting for a clock edge, set state=IDLE, s=0, z=1, out_valid=0, and clear the accumulator and chunk index.
REQ-026 When resetn=0, in_ready SHALL read 0.
REQ-027 A reset asserted during CALC or DONE SHALL discard the in-flight result; no out_valid pulse follows.
REQ-028 The first accept SHALL be possible on the first rising edge after resetn deasserts.

Verification
REQ-029 The bench SHALL cover these directed scenarios (WIDTH=32, CHUNK=8):
- ADD a=0xFFFFFFFF, b=1, out_ready=1 -> 1 cycle later out_valid=1, s=0, z=1.
- SRA a=4, b=0x80000000 -> s=0xF8000000. SRA a=40, same b -> s=0xFFFFFFFF. SRL a=40 -> s=0, z=1.
- HAMD a=0xFFFF0000, b=0x0000FFFF -> out_valid rises 5 cycles after accept, s=32, z=0, in_ready=0 during the 4 CALC cycles.
- Result held with out_ready=0 for 3 cycles while a, b and aluc toggle -> s, z and out_valid stable. Then out_ready=1 with in_valid=1 (XOR 0xA5A5A5A5, 0x5A5A5A5A) -> next cycle s=0xFFFFFFFF.
- resetn pulsed low in the 2nd CALC cycle of a HAMD -> s=0, z=1 and out_valid=0 immediately, with no stale result after release.
- Stream of 8 ANDs with in_valid=1 and out_ready=1 -> 8 consecutive out_valid cycles with matching results. Repeat with WIDTH=16, CHUNK=4: HAMD a=0xFFFF, b=0 -> s=16 after 5 cycles.

Source files
------------

// File: rtl/seq_alu.sv
// ============================================================================
// Module   : seq_alu
// Purpose  : single-issue ALU with valid/ready handshake and multi-cycle HAMD
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_alu #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       aluc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             z
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int ACC_W  = $clog2(WIDTH + 1);
   localparam int SHW    = $clog2(WIDTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0100;
   localparam logic [3:0] OP_AND  = 4'b0001;
   localparam logic [3:0] OP_OR   = 4'b0101;
   localparam logic [3:0] OP_XOR  = 4'b0010;
   localparam logic [3:0] OP_LUI  = 4'b0110;
   localparam logic [3:0] OP_SLL  = 4'b0011;
   localparam logic [3:0] OP_SRL  = 4'b0111;
   localparam logic [3:0] OP_SRA  = 4'b1111;
   localparam logic [3:0] OP_HAMD = 4'b1000;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             z_q, z_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] x_q, x_d;

   logic             accept;
   logic [WIDTH-1:0] alu_res;
   logic [SHW-1:0]   shamt;
   logic             shift_big;
   logic [CHUNK-1:0] chunk_bits;
   logic [ACC_W-1:0] chunk_cnt;
   logic [ACC_W-1:0] hamd_sum;

   assign in_ready  = resetn & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
   assign out_valid = (state_q == DONE);
   assign accept    = in_valid & in_ready;
   assign s         = s_q;
   assign z         = z_q;

   // Any shift amount at or beyond WIDTH saturates instead of wrapping.
   assign shamt     = a[SHW-1:0];
   assign shift_big = |(a >> SHW);

   always_comb begin
      alu_res = '0;
      case (aluc)
         OP_ADD: alu_res = a + b;
         OP_SUB: alu_res = a - b;
         OP_AND: alu_res = a & b;
         OP_OR:  alu_res = a | b;
         OP_XOR: alu_res = a ^ b;
         OP_LUI: alu_res = b << (WIDTH / 2);
         OP_SLL: alu_res = shift_big ? '0 : (b << shamt);
         OP_SRL: alu_res = shift_big ? '0 : (b >> shamt);
         OP_SRA: alu_res = shift_big ? {WIDTH{b[WIDTH-1]}}
                                     : $unsigned($signed(b) >>> shamt);
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      chunk_bits = x_q[int'(idx_q)*CHUNK +: CHUNK];
      chunk_cnt  = '0;
      for (int k = 0; k < CHUNK; k++) begin
         chunk_cnt = chunk_cnt + ACC_W'(chunk_bits[k]);
      end
      hamd_sum = acc_q + chunk_cnt;
   end

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      z_d     = z_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      x_d     = x_q;
      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               if (aluc == OP_HAMD) begin
                  acc_d   = '0;
                  idx_d   = '0;
                  x_d     = a ^ b;
                  state_d = CALC;
               end else begin
                  s_d     = alu_res;
                  z_d     = ~|alu_res;
                  state_d = DONE;
               end
            end else if (state_q == DONE && out_ready) begin
               state_d = IDLE;
            end
         end
         CALC: begin
            acc_d = hamd_sum;
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
               s_d     = {{(WIDTH-ACC_W){1'b0}}, hamd_sum};
               z_d     = ~|hamd_sum;
               idx_d   = '0;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         s_q     <= '0;
         z_q     <= 1'b1;
         acc_q   <= '0;
         idx_q   <= '0;
         x_q     <= '0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         z_q     <= z_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         x_q     <= x_d;
      end
   end

endmodule

`default_nettype wire
